// File: rtl/pipeline_ctrl.sv
// Pipeline controller for a five-stage in-order core.
// Sequences a single program run (IDLE -> RUN -> DRAIN -> DONE) and resolves
// per-cycle hazards into stall (hold) and flush (bubble) requests for the PC
// and the IF/ID, ID/EX and EX/MEM pipeline registers. It also keeps cycle and
// stall performance counters.
//
// Host handshake: start is a one-cycle request sampled only in IDLE. There is
// no ready/acknowledge. riscv_start rises on the edge that accepts it, and
// riscv_done rises on the edge that retires the final ecall. Both then hold
// until reset.
module pipeline_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        icache_stall,
    input  logic        dcache_stall,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic        id_ex_mem_read,
    input  logic [4:0]  id_ex_rd,
    input  logic        ex_branch_taken,
    input  logic        ex_mem_ecall,
    input  logic        mem_wb_ecall,
    output logic        riscv_start,
    output logic        riscv_done,
    output logic        pc_stall,
    output logic        if_id_stall,
    output logic        id_ex_stall,
    output logic        ex_mem_stall,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        ex_mem_flush,
    output logic [31:0] cycle_count,
    output logic [31:0] stall_count,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;
    logic   redirect_pending;
    logic   load_use;
    logic   active;

    assign state_dbg = state;
    assign active    = (state == RUN) || (state == DRAIN);

    // The instruction in ID needs a register that a load in EX has not produced yet.
    assign load_use = id_ex_mem_read && (id_ex_rd != 5'd0) &&
                      ((id_uses_rs1 && (id_rs1 == id_ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == id_ex_rd)));

    // State register, plus the run and finish levels decoded from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            riscv_start <= 1'b0;
            riscv_done  <= 1'b0;
        end else begin
            state       <= state_next;
            riscv_start <= (state_next != IDLE);
            riscv_done  <= (state_next == DONE);
        end
    end

    // Next-state logic: an ecall leaves MEM to start draining, then leaves WB to finish.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (ex_mem_ecall && !dcache_stall) state_next = DRAIN;
            DRAIN:   if (mem_wb_ecall && !dcache_stall) state_next = DONE;
            DONE:    state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    // Hazard resolution in priority order. The pending redirect flush is layered on last.
    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        id_ex_stall  = 1'b0;
        ex_mem_stall = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        if (active) begin
            if (dcache_stall) begin
                // MEM cannot complete, so the whole pipe freezes in place.
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_stall  = 1'b1;
                ex_mem_stall = 1'b1;
            end else if ((state == DRAIN) || ex_mem_ecall) begin
                // Nothing younger than the ecall is allowed to reach MEM.
                pc_stall     = 1'b1;
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
            end else if (ex_branch_taken) begin
                // The PC takes the redirect target, and the wrong-path IF and ID are squashed.
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
            end else if (load_use) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_flush  = 1'b1;
            end else if (icache_stall) begin
                pc_stall     = 1'b1;
                if_id_flush  = 1'b1;
            end
            // A fetch that was in flight when the branch redirected is stale.
            if (redirect_pending && !dcache_stall) begin
                if_id_flush  = 1'b1;
            end
        end
    end

    // Remember a redirect that landed while the icache was busy until that fetch is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            redirect_pending <= 1'b0;
        end else if ((state == RUN) && ex_branch_taken && icache_stall && !dcache_stall) begin
            redirect_pending <= 1'b1;
        end else if (!icache_stall && !dcache_stall) begin
            redirect_pending <= 1'b0;
        end
    end

    // Performance counters. They run only while the program executes and wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_count <= 32'd0;
            stall_count <= 32'd0;
        end else begin
            if (active) begin
                cycle_count <= cycle_count + 32'd1;
            end
            if ((state == RUN) && (dcache_stall || icache_stall || load_use)) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl. Inputs change on the falling edge. The
// combinational controls are sampled 1 ns later, and registered values are
// sampled on the falling edge that follows the rising edge that loads them.
module tb_pipeline_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic        icache_stall;
  logic        dcache_stall;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_uses_rs1;
  logic        id_uses_rs2;
  logic        id_ex_mem_read;
  logic [4:0]  id_ex_rd;
  logic        ex_branch_taken;
  logic        ex_mem_ecall;
  logic        mem_wb_ecall;
  logic        riscv_start;
  logic        riscv_done;
  logic        pc_stall;
  logic        if_id_stall;
  logic        id_ex_stall;
  logic        ex_mem_stall;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        ex_mem_flush;
  logic [31:0] cycle_count;
  logic [31:0] stall_count;
  logic [1:0]  state_dbg;

  // {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush, id_ex_flush, ex_mem_flush}
  logic [6:0]  ctrl;
  assign ctrl = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
                 if_id_flush, id_ex_flush, ex_mem_flush};

  localparam logic [6:0] C_NONE   = 7'b000_0000;
  localparam logic [6:0] C_FREEZE = 7'b111_1000;
  localparam logic [6:0] C_ECALL  = 7'b100_0111;
  localparam logic [6:0] C_BRANCH = 7'b000_0110;
  localparam logic [6:0] C_LDUSE  = 7'b110_0010;
  localparam logic [6:0] C_ICACHE = 7'b100_0100;
  localparam logic [6:0] C_REDIR  = 7'b000_0100;

  int total = 0;
  int bad   = 0;

  pipeline_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .icache_stall    (icache_stall),
    .dcache_stall    (dcache_stall),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_uses_rs1     (id_uses_rs1),
    .id_uses_rs2     (id_uses_rs2),
    .id_ex_mem_read  (id_ex_mem_read),
    .id_ex_rd        (id_ex_rd),
    .ex_branch_taken (ex_branch_taken),
    .ex_mem_ecall    (ex_mem_ecall),
    .mem_wb_ecall    (mem_wb_ecall),
    .riscv_start     (riscv_start),
    .riscv_done      (riscv_done),
    .pc_stall        (pc_stall),
    .if_id_stall     (if_id_stall),
    .id_ex_stall     (id_ex_stall),
    .ex_mem_stall    (ex_mem_stall),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .ex_mem_flush    (ex_mem_flush),
    .cycle_count     (cycle_count),
    .stall_count     (stall_count),
    .state_dbg       (state_dbg)
  );

  // Clock: 10 ns period, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    start           = 1'b0;
    icache_stall    = 1'b0;
    dcache_stall    = 1'b0;
    id_rs1          = 5'd0;
    id_rs2          = 5'd0;
    id_uses_rs1     = 1'b0;
    id_uses_rs2     = 1'b0;
    id_ex_mem_read  = 1'b0;
    id_ex_rd        = 5'd0;
    ex_branch_taken = 1'b0;
    ex_mem_ecall    = 1'b0;
    mem_wb_ecall    = 1'b0;
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    repeat (2) next_cycle();

    // Reset state, and no controls in IDLE even while a hazard input is up.
    check("rst_start", {31'd0, riscv_start}, 32'd0);
    check("rst_done", {31'd0, riscv_done}, 32'd0);
    check("rst_cycle", cycle_count, 32'd0);
    check("rst_stall", stall_count, 32'd0);
    icache_stall = 1'b1;
    #1 check("idle_ctrl", {25'd0, ctrl}, {25'd0, C_NONE});
    icache_stall = 1'b0;

    // Reset wins over start in the same cycle.
    start = 1'b1;
    next_cycle();
    check("rst_over_start", {31'd0, riscv_start}, 32'd0);
    reset = 1'b0;
    start = 1'b1;
    next_cycle();                                    // N1: running
    start = 1'b0;
    check("run_start", {31'd0, riscv_start}, 32'd1);
    check("run_cycle0", cycle_count, 32'd0);
    #1 check("run_ctrl_quiet", {25'd0, ctrl}, {25'd0, C_NONE});

    repeat (5) next_cycle();
    check("cycle_after5", cycle_count, 32'd5);
    check("stall_quiet", stall_count, 32'd0);

    // Load-use on rs2
    id_ex_mem_read = 1'b1; id_ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
    #1 check("lduse_rs2", {25'd0, ctrl}, {25'd0, C_LDUSE});
    next_cycle();
    check("lduse_cnt", stall_count, 32'd1);
    check("cycle_6", cycle_count, 32'd6);

    // x0 destination is never a hazard.
    id_ex_rd = 5'd0; id_rs2 = 5'd0;
    #1 check("lduse_x0", {25'd0, ctrl}, {25'd0, C_NONE});
    next_cycle();
    check("x0_no_cnt", stall_count, 32'd1);

    // Load-use on rs1, then the same with dcache_stall
    id_uses_rs2 = 1'b0; id_rs2 = 5'd7;
    id_rs1 = 5'd7; id_uses_rs1 = 1'b1; id_ex_rd = 5'd7;
    #1 check("lduse_rs1", {25'd0, ctrl}, {25'd0, C_LDUSE});
    next_cycle();
    check("lduse_cnt2", stall_count, 32'd2);
    dcache_stall = 1'b1;
    #1 check("dcache_freeze", {25'd0, ctrl}, {25'd0, C_FREEZE});
    next_cycle();
    check("dcache_cnt", stall_count, 32'd3);

    // A taken branch overrides the load-use hazard.
    dcache_stall = 1'b0; ex_branch_taken = 1'b1;
    #1 check("branch_over_ld", {25'd0, ctrl}, {25'd0, C_BRANCH});
    next_cycle();

    // icache stall alone
    clear_inputs();
    icache_stall = 1'b1;
    #1 check("icache", {25'd0, ctrl}, {25'd0, C_ICACHE});
    next_cycle();

    // Branch during an icache stall: the flush holds through the release cycle.
    ex_branch_taken = 1'b1;
    #1 check("redir_branch", {25'd0, ctrl}, {25'd0, C_BRANCH});
    next_cycle();
    ex_branch_taken = 1'b0;
    #1 check("redir_wait1", {25'd0, ctrl}, {25'd0, C_ICACHE});
    next_cycle();
    dcache_stall = 1'b1;
    #1 check("redir_dcache", {25'd0, ctrl}, {25'd0, C_FREEZE});
    next_cycle();
    icache_stall = 1'b0; dcache_stall = 1'b0;
    #1 check("redir_release", {25'd0, ctrl}, {25'd0, C_REDIR});
    next_cycle();
    #1 check("redir_cleared", {25'd0, ctrl}, {25'd0, C_NONE});

    // An ecall held by dcache_stall, then an ecall that beats a branch
    ex_mem_ecall = 1'b1; dcache_stall = 1'b1;
    #1 check("ecall_dcache", {25'd0, ctrl}, {25'd0, C_FREEZE});
    next_cycle();                                    // N17
    dcache_stall = 1'b0; ex_branch_taken = 1'b1;
    #1 check("ecall_run", {25'd0, ctrl}, {25'd0, C_ECALL});
    check("cycle_16", cycle_count, 32'd16);
    next_cycle();                                    // N18: draining
    clear_inputs();
    mem_wb_ecall = 1'b1;
    #1 check("drain_ctrl", {25'd0, ctrl}, {25'd0, C_ECALL});
    check("drain_notdone", {31'd0, riscv_done}, 32'd0);
    next_cycle();                                    // N19: done
    clear_inputs();
    check("done", {31'd0, riscv_done}, 32'd1);
    check("done_start", {31'd0, riscv_start}, 32'd1);
    check("done_cycle", cycle_count, 32'd18);

    // DONE ignores start and all hazards, and the counters freeze.
    start = 1'b1; icache_stall = 1'b1; dcache_stall = 1'b1;
    #1 check("done_ctrl", {25'd0, ctrl}, {25'd0, C_NONE});
    repeat (2) next_cycle();
    check("done_hold", {31'd0, riscv_done}, 32'd1);
    check("done_cycle_frz", cycle_count, 32'd18);

    // New run, then reset in DRAIN at cycle_count = 0x10.
    clear_inputs();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    start = 1'b1;
    next_cycle();                                    // running, count 0
    start = 1'b0;
    repeat (14) next_cycle();                        // count 14
    ex_mem_ecall = 1'b1;
    next_cycle();                                    // draining, count 15
    ex_mem_ecall = 1'b0;
    next_cycle();                                    // count 16
    check("drain_cycle10", cycle_count, 32'h10);
    #1 check("drain_hold", {25'd0, ctrl}, {25'd0, C_ECALL});
    reset = 1'b1;
    next_cycle();
    check("rst_drain_cyc", cycle_count, 32'd0);
    check("rst_drain_stl", stall_count, 32'd0);
    check("rst_drain_start", {31'd0, riscv_start}, 32'd0);
    check("rst_drain_done", {31'd0, riscv_done}, 32'd0);
    check("rst_drain_ctrl", {25'd0, ctrl}, {25'd0, C_NONE});

    // Reset also clears a pending redirect.
    reset = 1'b0;
    start = 1'b1;
    next_cycle();
    start = 1'b0; ex_branch_taken = 1'b1; icache_stall = 1'b1;
    next_cycle();                                    // redirect now pending
    ex_branch_taken = 1'b0; reset = 1'b1;
    next_cycle();
    reset = 1'b0; icache_stall = 1'b0; start = 1'b1;
    next_cycle();
    start = 1'b0;
    #1 check("rst_redirect", {25'd0, ctrl}, {25'd0, C_NONE});

    // Wrap: load 0xFFFF_FFFF, then one RUN cycle gives 0.
    force dut.cycle_count = 32'hFFFF_FFFF;
    #1 release dut.cycle_count;
    next_cycle();
    check("cycle_wrap", cycle_count, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001: clk  in  1  rising-edge clock for all state.
REQ-002: reset  in  1  reset, synchronous, active-high; clock clk.
REQ-003: start  in  1  one-cycle run request from the host.
REQ-004: icache_stall  in  1  instruction fetch not ready.
REQ-005: dcache_stall  in  1  data access in the MEM stage not ready.
REQ-006: id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
REQ-007: id_uses_rs1, id_uses_rs2  in  1 each  ID instruction reads that source.
REQ-008: id_ex_mem_read, id_ex_rd  in  1, 5  load flag and destination register of the instruction in EX.
REQ-009: ex_branch_taken  in  1  taken branch or jump resolved in EX.
REQ-010: ex_mem_ecall, mem_wb_ecall  in  1 each  ecall in MEM or WB.
REQ-011: riscv_start, riscv_done  out  1 each  registered run and finish levels sent to all pipeline registers.
REQ-012: pc_stall, if_id_stall, id_ex_stall, ex_mem_stall  out  1 each  hold the named register.
REQ-013: if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  load a bubble into the named register.
REQ-014: cycle_count, stall_count  out  32 each  performance counters.

Function
REQ-015: The FSM SHALL have states IDLE, RUN, DRAIN, DONE, with riscv_start=1 in RUN, DRAIN and DONE, and riscv_done=1 only in DONE.
REQ-016: IDLE->RUN SHALL occur on start=1; start SHALL be ignored in every other state.
REQ-017: RUN->DRAIN SHALL occur on ex_mem_ecall=1 && dcache_stall=0.
REQ-018: DRAIN->DONE SHALL occur on mem_wb_ecall=1 && dcache_stall=0, and DONE SHALL persist until reset.
REQ-019: Stall and flush outputs SHALL be combinational, SHALL be asserted only in RUN and DRAIN, and SHALL be 0 in IDLE and DONE.
REQ-020: Priority 1: dcache_stall=1 SHALL assert all four stalls and no flush, freezing the whole pipe.
REQ-021: Priority 2: in RUN, ex_mem_ecall=1 SHALL assert pc_stall, if_id_flush, id_ex_flush and ex_mem_flush, so no younger instruction reaches MEM.
REQ-022: In DRAIN, without dcache_stall, pc_stall, if_id_flush, id_ex_flush and ex_mem_flush SHALL be held at 1.
REQ-023: Priority 3: ex_branch_taken=1 SHALL assert if_id_flush and id_ex_flush, with pc_stall=0.
REQ-024: Priority 4: a load-use hazard SHALL assert pc_stall, if_id_stall and id_ex_flush.
REQ-025: A load-use hazard SHALL be defined as id_ex_mem_read && id_ex_rd!=0 && ((id_uses_rs1 && id_rs1==id_ex_rd) || (id_uses_rs2 && id_rs2==id_ex_rd)).
REQ-026: Priority 5: icache_stall=1 SHALL assert pc_stall and if_id_flush, while later stages advance.
REQ-027: A taken branch SHALL override a simultaneous load-use hazard.
REQ-028: Flag redirect_pending SHALL be set when ex_branch_taken && icache_stall && !dcache_stall in RUN.
REQ-029: While redirect_pending=1, if_id_flush SHALL be 1 except under priority 1.
REQ-030: redirect_pending SHALL clear at the end of the first cycle with icache_stall=0 && dcache_stall=0, and that cycle's stale fetch SHALL be flushed.
REQ-031: cycle_count SHALL increment by 1 every cycle in RUN or DRAIN, and SHALL wrap modulo 2^32.
REQ-032: stall_count SHALL increment by 1 every RUN cycle with dcache_stall, icache_stall or a load-use hazard active, and SHALL wrap modulo 2^32.
REQ-033: Both counters SHALL hold their values in IDLE and DONE.

Reset
REQ-034: reset=1 SHALL, on the next edge, force IDLE, riscv_start=0, riscv_done=0, redirect_pending=0, cycle_count=0 and stall_count=0, in any state including mid-run.
REQ-035: reset SHALL override start when both are asserted in the same cycle.

Verification
REQ-036: start pulse at cycle 0 -> riscv_start=1 from cycle 1; cycle_count=5 after 5 RUN cycles.
REQ-037: id_ex_mem_read=1, id_ex_rd=5, id_rs2=5, id_uses_rs2=1 -> pc_stall=1, if_id_stall=1, id_ex_flush=1; stall_count +1.
REQ-038: Same inputs as REQ-037 plus dcache_stall=1 -> all four stalls=1, all flushes=0; branch_taken=1 with a load-use hazard -> if_id_flush=1, id_ex_flush=1, pc_stall=0.
REQ-039: Branch taken during icache_stall, then icache_stall drops 3 cycles later -> if_id_flush=1 through the release cycle, then 0.
REQ-040: ex_mem_ecall=1, then mem_wb_ecall=1 -> ex_mem_flush=1 in both cycles; riscv_done=1 one cycle later; cycle_count then frozen.
REQ-041: reset asserted in DRAIN with cycle_count=0x0000_0010 -> IDLE, all counters 0, all outputs 0; cycle_count=0xFFFF_FFFF plus one RUN cycle -> 0.
